// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory slave with byte lanes, load extension and fault checking
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic        Ready,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        Fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic cap_write;
  logic [31:0] cap_addr, cap_wdata;
  logic [2:0] cap_f3;
  logic write, fault, enter_resp;
  logic [31:0] addr, wdata, word, lane, ld, st;
  logic [2:0] f3;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  // state register
  always_ff @(posedge CLK)
    if (!RST) state <= IDLE;
    else state <= next;
  // next-state logic; a request is only looked at in IDLE
  always_comb
    next = (state == IDLE) ? (Req ? ((WAIT_STATES > 0) ? WAIT : RESP) : IDLE) :
           (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT) : IDLE;
  // handshake outputs decoded from state alone
  always_comb begin
    Ready = state == IDLE;
    RespValid = state == RESP;
  end
  // wait counter and request capture
  always_ff @(posedge CLK)
    if (!RST) cnt <= 4'd0;
    else if (state == IDLE && Req) begin
      cnt <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
      cap_write <= ReqWrite;
      cap_addr <= Addr;
      cap_wdata <= WriteData;
      cap_f3 <= Funct3;
    end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  // with zero wait states RESP is entered on the capture edge, so use the live inputs while idle
  always_comb begin
    write = (state == IDLE) ? ReqWrite : cap_write;
    addr = (state == IDLE) ? Addr : cap_addr;
    wdata = (state == IDLE) ? WriteData : cap_wdata;
    f3 = (state == IDLE) ? Funct3 : cap_f3;
    idx = addr[AW+1:2];
    fault = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && write) ||
            (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) ||
            ((addr >> (AW + 2)) != 32'd0);
    enter_resp = RST && next == RESP;
    word = mem[idx];
    lane = word >> {addr[1:0], 3'b000};
    ld = (f3 == 3'b000) ? {{24{lane[7]}}, lane[7:0]} :
         (f3 == 3'b001) ? {{16{lane[15]}}, lane[15:0]} :
         (f3 == 3'b100) ? {24'd0, lane[7:0]} :
         (f3 == 3'b101) ? {16'd0, lane[15:0]} : word;
    st = (f3[1:0] == 2'b00) ? {4{wdata[7:0]}} : (f3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
    be = (f3[1:0] == 2'b00) ? 4'b0001 << addr[1:0] :
         (f3[1:0] == 2'b01) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  // response registers are loaded only on the edge entering RESP and cleared otherwise
  always_ff @(posedge CLK)
    if (!enter_resp) begin
      ReadData <= 32'd0;
      Fault <= 1'b0;
    end else begin
      ReadData <= (fault || write) ? 32'd0 : ld;
      Fault <= fault;
    end
  // store commit on the edge entering RESP; contents survive reset
  always_ff @(posedge CLK)
    if (enter_resp && write && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= st[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: byte-level reference model checks for two responders (2 and 0 wait states)
module tb_data_mem_responder;
  logic CLK = 0, RST = 0, req_a = 0, req_b = 0, write = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [2:0] f3 = 0;
  logic ready_a, rv_a, fault_a, ready_b, rv_b, fault_b;
  logic [31:0] rd_a, rd_b;
  logic sel = 0;
  logic rdy, rv, flt;
  logic [31:0] rd;
  int checks = 0, errors = 0;
  logic [7:0] mem_a [int unsigned];
  logic [7:0] mem_b [int unsigned];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_a (
    .CLK(CLK), .RST(RST), .Req(req_a), .ReqWrite(write), .Addr(addr), .WriteData(wdata),
    .Funct3(f3), .Ready(ready_a), .RespValid(rv_a), .ReadData(rd_a), .Fault(fault_a));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .CLK(CLK), .RST(RST), .Req(req_b), .ReqWrite(write), .Addr(addr), .WriteData(wdata),
    .Funct3(f3), .Ready(ready_b), .RespValid(rv_b), .ReadData(rd_b), .Fault(fault_b));

  always #5 CLK = ~CLK;
  assign rdy = sel ? ready_b : ready_a;
  assign rv = sel ? rv_b : rv_a;
  assign flt = sel ? fault_b : fault_a;
  assign rd = sel ? rd_b : rd_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_fault(input bit wr, input logic [31:0] a, input logic [2:0] fn);
    int sz;
    if (fn == 3'b011 || fn == 3'b110 || fn == 3'b111) return 1;
    if (fn[2] && wr) return 1;
    sz = 1 << fn[1:0];
    if (a % sz != 0) return 1;
    return a >= 32'd4096;
  endfunction

  function automatic logic [7:0] get_byte(input bit b, input int unsigned a);
    return b ? mem_b[a] : mem_a[a];
  endfunction

  function automatic logic [31:0] model_load(input bit b, input logic [31:0] a, input logic [2:0] fn);
    int sz = 1 << fn[1:0];
    longint v = 0;
    for (int i = 0; i < sz; i++) v += longint'(get_byte(b, a + i)) << (8 * i);
    if (!fn[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return 32'(v);
  endfunction

  task automatic model_store(input bit b, input logic [31:0] a, input logic [31:0] d, input logic [2:0] fn);
    int sz = 1 << fn[1:0];
    for (int i = 0; i < sz; i++)
      if (b) mem_b[a + i] = 8'(d >> (8 * i));
      else mem_a[a + i] = 8'(d >> (8 * i));
  endtask

  // one access; enters and leaves at a falling edge, hold keeps Req high throughout
  task automatic txn(input string t, input bit b, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] fn, input bit hold);
    bit f = exp_fault(wr, a, fn);
    logic [31:0] exp_rd = (f || wr) ? 32'd0 : model_load(b, a, fn);
    int lat = 0;
    if (wr && !f) model_store(b, a, d, fn);
    sel = b;
    check({t, ":ready"}, rdy, 1);
    write = wr; addr = a; wdata = d; f3 = fn;
    if (b) req_b = 1; else req_a = 1;
    @(posedge CLK);
    #1;
    if (!hold) begin req_a = 0; req_b = 0; end
    while (lat < 20) begin
      @(negedge CLK);
      lat++;
      if (rv) break;
      check({t, ":busy"}, rdy, 0);
    end
    check({t, ":latency"}, lat, b ? 1 : 3);
    check({t, ":fault"}, flt, f);
    check({t, ":rdata"}, rd, exp_rd);
    @(negedge CLK);
    check({t, ":rv_drop"}, rv, 0);
    check({t, ":idle"}, rdy, 1);
    check({t, ":rdata_idle"}, rd, 0);
  endtask

  initial begin
    req_a = 1; req_b = 1;
    repeat (3) begin
      @(negedge CLK);
      check("rst_ready", ready_a, 1);
      check("rst_rv", rv_a, 0);
      check("rst_rdata", rd_a, 0);
      check("rst_fault", fault_a, 0);
      check("rst_ready_b", ready_b, 1);
      check("rst_rv_b", rv_b, 0);
    end
    RST = 1; req_a = 0; req_b = 0;

    txn("sw10", 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
    txn("lw10", 0, 0, 32'h10, 0, 3'b010, 0);
    txn("sw20", 0, 1, 32'h20, 32'h11223344, 3'b010, 0);
    txn("sb21", 0, 1, 32'h21, 32'h000000AA, 3'b000, 0);
    txn("sh22", 0, 1, 32'h22, 32'h0000BEEF, 3'b001, 0);
    txn("lw20", 0, 0, 32'h20, 0, 3'b010, 0);
    txn("lb21", 0, 0, 32'h21, 0, 3'b000, 0);
    txn("lbu21", 0, 0, 32'h21, 0, 3'b100, 0);
    txn("lh22", 0, 0, 32'h22, 0, 3'b001, 0);
    txn("lhu22", 0, 0, 32'h22, 0, 3'b101, 0);
    txn("sw00", 0, 1, 32'h0, 32'h01020304, 3'b010, 0);
    txn("f_lw12", 0, 0, 32'h12, 0, 3'b010, 0);
    txn("f_lh13", 0, 0, 32'h13, 0, 3'b001, 0);
    txn("f_sw1000", 0, 1, 32'h1000, 32'h55555555, 3'b010, 0);
    txn("f_f3_011", 0, 1, 32'h20, 32'h66666666, 3'b011, 0);
    txn("f_sbu", 0, 1, 32'h10, 32'h77777777, 3'b100, 0);
    txn("f_sh11", 0, 1, 32'h11, 32'h88888888, 3'b001, 0);
    txn("lw00_after", 0, 0, 32'h0, 0, 3'b010, 0);
    txn("lw10_after", 0, 0, 32'h10, 0, 3'b010, 0);
    txn("lw20_after", 0, 0, 32'h20, 0, 3'b010, 0);
    txn("hold1", 0, 0, 32'h10, 0, 3'b010, 1);
    txn("hold2", 0, 0, 32'h20, 0, 3'b010, 0);

    txn("b_sw30", 1, 1, 32'h30, 32'hA5A55A5A, 3'b010, 0);
    txn("b_sb33", 1, 1, 32'h33, 32'h000000C3, 3'b000, 0);
    txn("b_lw30", 1, 0, 32'h30, 0, 3'b010, 1);
    txn("b_lb33", 1, 0, 32'h33, 0, 3'b000, 0);
    txn("b_f_lw31", 1, 0, 32'h31, 0, 3'b010, 0);

    txn("sw40", 0, 1, 32'h40, 32'hCAFEF00D, 3'b010, 0);
    sel = 0;
    write = 1; addr = 32'h40; wdata = 32'h12345678; f3 = 3'b010; req_a = 1;
    @(posedge CLK);
    #1 req_a = 0;
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    check("midrst_ready", ready_a, 1);
    check("midrst_rv", rv_a, 0);
    RST = 1;
    repeat (4) begin
      @(negedge CLK);
      check("midrst_no_rv", rv_a, 0);
    end
    txn("lw40_after_rst", 0, 0, 32'h40, 0, 3'b010, 0);

    for (int i = 0; i < 16; i++) txn("init", 0, 1, 32'h100 + 4 * i, $urandom, 3'b010, 0);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                                   : 32'h100 + $urandom_range(0, 63);
      txn("rand", 0, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
